dmd_pattern_fetch_sched: RTL
============================

# dmd_pattern_fetch_sched

Trigger-driven scheduler that sequences memory read bursts for one DMD pattern (frame) per trigger into the row read FIFO feeding `DMD_trigger_control`. It sits between the trigger input and the memory read port. On each accepted trigger it computes the current pattern's base address and issues fixed-length bursts, throttled by the FIFO's programmable-full flag. After each frame it advances a wrapping pattern index.

## Interface

Parameters:
- `ADDR_W`, 27: memory word address width; the address unit is one 128-bit word.
- `WORDS_PER_PATTERN`, 6144: 128-bit words per pattern; must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 64: words per read burst.
- `IDX_W`, 4: pattern index width, giving up to 16 patterns.

Ports:
- `clk_g`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `trigger`  in  1: frame trigger, level input; the rising edge is detected internally.
- `mem_preload_done`  in  1: pattern memory is valid; triggers are ignored while this is 0.
- `cfg_base_addr`  in  ADDR_W: address of pattern 0.
- `cfg_num_patterns`  in  IDX_W: number of patterns; 0 is treated as 1.
- `fifo_prog_full`  in  1: row FIFO cannot absorb another burst.
- `mem_rd_req`  out  1: burst request.
- `mem_rd_addr`  out  ADDR_W: burst start address.
- `mem_rd_len`  out  8: burst length, equal to `BURST_LEN`-1.
- `mem_rd_ack`  in  1: request accepted in this cycle.
- `busy`  out  1: a frame fetch is in progress.
- `pattern_idx`  out  IDX_W: index of the pattern being fetched, or of the next pattern when idle.
- `frame_done`  out  1: one-cycle pulse when the last burst of a frame is acknowledged.
- `trigger_overrun`  out  1: one-cycle pulse when a trigger is dropped.

## Operation

- Trigger edge detect: `trig_q` is a register of `trigger`; a trigger event is `trigger & ~trig_q`.
- States: IDLE, WAIT_ROOM, REQ, DONE.
- IDLE:
  - A trigger event with `mem_preload_done`=1 latches `nump = max(cfg_num_patterns,1)`.
  - It sets `addr = cfg_base_addr + pattern_idx*WORDS_PER_PATTERN` (mod 2^ADDR_W) and clears `burst_cnt`.
  - Next state is WAIT_ROOM.
  - A trigger event with `mem_preload_done`=0 is ignored, with no overrun.
- WAIT_ROOM: go to REQ when `fifo_prog_full`=0; otherwise stay.
- REQ:
  - Hold `mem_rd_req`=1 with `mem_rd_addr`=`addr` stable until `mem_rd_ack`.
  - On ack, `addr += BURST_LEN` (wraps mod 2^ADDR_W) and `burst_cnt++`.
  - If this was the last burst (`burst_cnt == WORDS_PER_PATTERN/BURST_LEN - 1`), go to DONE; otherwise go to WAIT_ROOM.
  - `mem_rd_ack` is ignored in any state other than REQ.
- DONE:
  - `frame_done`=1 for one cycle.
  - `pattern_idx` becomes 0 if `pattern_idx >= nump-1`, otherwise `pattern_idx+1`.
  - Next state is IDLE.
- A trigger event in any state other than IDLE is dropped and pulses `trigger_overrun`; the exception is the pending slot described in Configuration.
- `busy`=1 in every state except IDLE.
- `cfg_*` inputs are sampled only at trigger acceptance; changes mid-frame take effect on the next frame.

## Timing

- Reset values: state IDLE; `mem_rd_req`=0, `mem_rd_addr`=0, `mem_rd_len`=`BURST_LEN`-1 (constant), `busy`=0, `pattern_idx`=0, `frame_done`=0, `trigger_overrun`=0; `trig_q`=0; pending flag=0.
- Trigger accepted at edge n gives `busy`=1 at n+1. With `fifo_prog_full`=0, `mem_rd_req`=1 at n+2.
- All outputs are registered.
- Ack at edge m deasserts `mem_rd_req` at m+1. The next request is asserted at m+2 at the earliest.
- `frame_done` is high in the cycle after the final ack. `pattern_idx` is updated in the cycle after that. IDLE is reached one cycle after `frame_done`.
- A `fifo_prog_full` rise while in REQ does not withdraw the held request.
- `rst` mid-frame: all state returns to reset values in the next cycle, `pattern_idx` becomes 0, and an outstanding request is abandoned.

## Configuration

- `DMD_TRIG_QUEUE_EN` defined:
  - A single pending-trigger flag is added.
  - The first trigger event while busy sets the flag without an overrun.
  - In IDLE with the flag set and `mem_preload_done`=1, the flag is cleared and the fetch starts as for a trigger event, one cycle after entering IDLE.
  - A further trigger event while the flag is set pulses `trigger_overrun`.
  - `rst` clears the flag.
- `DMD_TRIG_QUEUE_EN` undefined: no flag; every trigger event while busy pulses `trigger_overrun`.

## Test plan

- Single frame, address sequence:
  - Stimulus: `cfg_base_addr`=0x100, nump=3, ack on every request, `fifo_prog_full`=0.
  - Required: 96 requests at addresses 0x100…0x18C0 in steps of 0x40, `mem_rd_len`=63, one `frame_done`, then `pattern_idx`=1.
- Pattern wrap:
  - Stimulus: four triggers with nump=3, each after IDLE.
  - Required: first addresses 0x100, 0x1900, 0x3100, 0x100; `pattern_idx` sequence 1, 2, 0, 1.
- Throttle:
  - Stimulus: hold `fifo_prog_full`=1 after the 10th ack for 50 cycles.
  - Required: no `mem_rd_req` during the hold; the 11th request has address base+0x280; 96 bursts in total.
- Overrun:
  - Stimulus: a second trigger edge mid-frame.
  - Required without the macro: `trigger_overrun` pulses once and only 96 bursts are issued.
  - Required with `DMD_TRIG_QUEUE_EN`: no overrun; 192 bursts; a third edge mid-frame pulses the overrun.
- Gating and reset:
  - Stimulus: trigger with `mem_preload_done`=0.
  - Required: `busy` stays 0 and no overrun.
  - Stimulus: `rst` after the 40th ack.
  - Required: next cycle `mem_rd_req`=0, `busy`=0, `pattern_idx`=0; a new trigger restarts at `cfg_base_addr`.
- Address wrap:
  - Stimulus: `cfg_base_addr`=2^27−0x80.
  - Required: the third burst address is 0x0.

Source files
------------

// File: rtl/dmd_pattern_fetch_sched_if.sv
// dmd_pattern_fetch_sched_if: burst read request port between the frame fetch scheduler and the memory reader.
interface dmd_pattern_fetch_sched_if #(
    parameter int ADDR_W = 27
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_len;
    logic              mem_rd_ack;
    modport master (output mem_rd_req, mem_rd_addr, mem_rd_len, input mem_rd_ack);
    modport slave (input mem_rd_req, mem_rd_addr, mem_rd_len, output mem_rd_ack);
endinterface

// File: rtl/dmd_pattern_fetch_sched.sv
// dmd_pattern_fetch_sched: per-trigger scheduler issuing FIFO-throttled read bursts for one DMD pattern.
// Define DMD_TRIG_QUEUE_EN to hold one trigger that arrives while a frame is in flight.
module dmd_pattern_fetch_sched #(
    parameter int ADDR_W            = 27,
    parameter int WORDS_PER_PATTERN = 6144,
    parameter int BURST_LEN         = 64,
    parameter int IDX_W             = 4
) (
    input  logic                 clk_g,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 mem_preload_done,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic [IDX_W-1:0]     cfg_num_patterns,
    input  logic                 fifo_prog_full,
    dmd_pattern_fetch_sched_if.master mem,
    output logic                 busy,
    output logic [IDX_W-1:0]     pattern_idx,
    output logic                 frame_done,
    output logic                 trigger_overrun
);
    localparam int NBURST = WORDS_PER_PATTERN / BURST_LEN;
    localparam int CNT_W  = NBURST > 1 ? $clog2(NBURST) : 1;
    typedef enum logic [1:0] {IDLE, WAIT_ROOM, REQ, DONE} state_t;
    state_t state, state_n;
    logic trig_q, trig_ev, start, overrun_n, last;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  burst_cnt;
    logic [IDX_W-1:0]  nump;
    assign trig_ev = trigger & ~trig_q;
    assign last = burst_cnt == CNT_W'(NBURST - 1);
    assign mem.mem_rd_addr = addr;
    assign mem.mem_rd_len = 8'(BURST_LEN - 1);
`ifdef DMD_TRIG_QUEUE_EN
    logic pend;
    assign start = state == IDLE && mem_preload_done && (trig_ev || pend);
    assign overrun_n = trig_ev && state != IDLE && pend;
    always_ff @(posedge clk_g) begin
        if (rst) pend <= 1'b0;
        else if (start) pend <= 1'b0;
        else if (trig_ev && state != IDLE) pend <= 1'b1;
    end
`else
    assign start = state == IDLE && mem_preload_done && trig_ev;
    assign overrun_n = trig_ev && state != IDLE;
`endif
    always_ff @(posedge clk_g) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? WAIT_ROOM : IDLE;
            WAIT_ROOM: state_n = fifo_prog_full ? WAIT_ROOM : REQ;
            REQ:       state_n = !mem.mem_rd_ack ? REQ : last ? DONE : WAIT_ROOM;
            default:   state_n = IDLE;
        endcase
    end
    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            trig_q          <= 1'b0;
            addr            <= '0;
            burst_cnt       <= '0;
            nump            <= IDX_W'(1);
            pattern_idx     <= '0;
            mem.mem_rd_req  <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            trigger_overrun <= 1'b0;
        end else begin
            trig_q          <= trigger;
            mem.mem_rd_req  <= state_n == REQ;
            busy            <= state_n != IDLE;
            frame_done      <= state_n == DONE;
            trigger_overrun <= overrun_n;
            if (start) begin
                nump      <= cfg_num_patterns == '0 ? IDX_W'(1) : cfg_num_patterns;
                addr      <= cfg_base_addr + ADDR_W'(pattern_idx) * ADDR_W'(WORDS_PER_PATTERN);
                burst_cnt <= '0;
            end
            if (state == REQ && mem.mem_rd_ack) begin
                addr      <= addr + ADDR_W'(BURST_LEN);
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            if (state == DONE)
                pattern_idx <= pattern_idx >= nump - IDX_W'(1) ? '0 : pattern_idx + IDX_W'(1);
        end
    end
endmodule
